// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and control unit for the 5-stage MIPS core. From decoded
//   ID-stage information and the write-back info of EXE/MEM/WB it produces:
//     - EXE operand forwarding selects (fwd_a / fwd_b)
//     - load-use stalls (ID/IF frozen, bubble into EXE)
//     - a branch-shadow squash of ID lasting BRANCH_SHADOW advancing cycles
//     - multi-cycle EXE occupancy for mul/div instructions
//     - debug halt with single-cycle stepping on debug_step rising edges
//     - stall / flush performance counters
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   debug_en, debug_step          debug halt / step request (edge-sensitive)
//   addr_rs_id, addr_rt_id        ID source registers
//   rs_used_id, rt_used_id        ID instruction actually reads rs / rt
//   is_branch_id, is_muldiv_id    ID instruction class
//   addr_rs_exe, addr_rt_exe      EXE source registers
//   regw_addr_exe, wb_wen_exe, mem_ren_exe   EXE write-back info
//   regw_addr_mem, wb_wen_mem, mem_ren_mem   MEM write-back info
//   regw_addr_wb, wb_wen_wb                  WB write-back info
//   fwd_a, fwd_b                  00 regfile, 01 MEM ALU, 10 MEM load, 11 WB
//   *_en, *_rst                   per-stage enable / bubble reset
//   exe_busy                      multi-cycle op occupying EXE
//   stall_count, flush_count      wrapping performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int ADDR_W        = 5,
  parameter int BRANCH_SHADOW = 3,
  parameter int MULDIV_LAT    = 4,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [ADDR_W-1:0] addr_rs_id,
  input  logic [ADDR_W-1:0] addr_rt_id,
  input  logic              rs_used_id,
  input  logic              rt_used_id,
  input  logic              is_branch_id,
  input  logic              is_muldiv_id,
  input  logic [ADDR_W-1:0] addr_rs_exe,
  input  logic [ADDR_W-1:0] addr_rt_exe,
  input  logic [ADDR_W-1:0] regw_addr_exe,
  input  logic              wb_wen_exe,
  input  logic              mem_ren_exe,
  input  logic [ADDR_W-1:0] regw_addr_mem,
  input  logic              wb_wen_mem,
  input  logic              mem_ren_mem,
  input  logic [ADDR_W-1:0] regw_addr_wb,
  input  logic              wb_wen_wb,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic              exe_busy,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [2:0] SHADOW_LOAD = 3'(BRANCH_SHADOW - 1);
  localparam logic [3:0] BUSY_LOAD   = 4'(MULDIV_LAT - 1);

  logic [2:0] shadow_cnt;
  logic [3:0] busy_cnt;
  logic       step_prev;

  logic hold;
  logic busy_active;
  logic load_use;
  logic adv_id;
  logic squash;
  logic stall_ev;
  logic flush_ev;

  // ---------------------------------------------------------------------------
  // Forwarding: the younger producer (MEM) wins over WB; r0 is never forwarded.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src);
    logic mem_hit;
    logic wb_hit;
    mem_hit = wb_wen_mem && (regw_addr_mem != '0) && (regw_addr_mem == src);
    wb_hit  = wb_wen_wb  && (regw_addr_wb  != '0) && (regw_addr_wb  == src);
    if (mem_hit)     fwd_sel = mem_ren_mem ? 2'b10 : 2'b01;
    else if (wb_hit) fwd_sel = 2'b11;
    else             fwd_sel = 2'b00;
  endfunction

  assign fwd_a = fwd_sel(addr_rs_exe);
  assign fwd_b = fwd_sel(addr_rt_exe);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A step only counts on its rising edge, so a held step button releases a
  // single cycle.
  assign hold        = debug_en && !(debug_step && !step_prev);
  assign busy_active = (busy_cnt != '0);

  assign load_use = wb_wen_exe && mem_ren_exe && (regw_addr_exe != '0) &&
                    ((rs_used_id && (regw_addr_exe == addr_rs_id)) ||
                     (rt_used_id && (regw_addr_exe == addr_rt_id)));

  assign adv_id = !rst && !hold && !busy_active && !load_use;
  assign squash = (adv_id && is_branch_id) || (shadow_cnt != '0);

  // Outputs are masked during reset so a busy count being cleared by this
  // edge is not visible.
  assign exe_busy = busy_active && !rst;

  // ---------------------------------------------------------------------------
  // Stage enable / reset priority (first match wins)
  // ---------------------------------------------------------------------------
  always_comb begin
    if_en    = 1'b1;
    id_en    = 1'b1;
    exe_en   = 1'b1;
    mem_en   = 1'b1;
    wb_en    = 1'b1;
    if_rst   = 1'b0;
    id_rst   = 1'b0;
    exe_rst  = 1'b0;
    mem_rst  = 1'b0;
    wb_rst   = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (rst) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (hold) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (busy_active) begin
      // EXE keeps computing; MEM receives bubbles until the result is ready.
      if_en    = 1'b0;
      id_en    = 1'b0;
      exe_en   = 1'b0;
      mem_rst  = 1'b1;
      stall_ev = 1'b1;
    end else if (load_use) begin
      if_en    = 1'b0;
      id_en    = 1'b0;
      exe_rst  = 1'b1;
      stall_ev = 1'b1;
    end else if (squash) begin
      id_rst   = 1'b1;
      flush_ev = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State: step edge detector, shadow / busy counters, perf counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev   <= 1'b0;
      shadow_cnt  <= '0;
      busy_cnt    <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      step_prev <= debug_step;
      if (!hold) begin
        // The load only happens when the branch itself advances, so a branch
        // stuck behind a load-use stall does not start its shadow early.
        if (adv_id && is_branch_id)
          shadow_cnt <= SHADOW_LOAD;
        else if ((shadow_cnt != '0) && !busy_active)
          shadow_cnt <= shadow_cnt - 3'd1;

        if (adv_id && is_muldiv_id && (MULDIV_LAT > 1))
          busy_cnt <= BUSY_LOAD;
        else if (busy_active)
          busy_cnt <= busy_cnt - 4'd1;

        if (stall_ev) stall_count <= stall_count + 1'b1;
        if (flush_ev) flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule
